// File: rtl/softmax_parallel.sv
// softmax_parallel: ten-lane hyperbolic-CORDIC exp, shared sum, restoring divide, FP32 pack
module softmax_parallel (
  input  logic [31:0] e1, e2, e3, e4, e5, e6, e7, e8, e9, e10,
  input  logic        clk,
  input  logic        EN,
  output logic [31:0] s1, s2, s3, s4, s5, s6, s7, s8, s9, s10,
  input  logic        rst_n
);
  typedef enum logic [1:0] {IDLE, CORDIC, DIVIDE, PACK} state_t;
  localparam logic signed [31:0] X0 = 32'sd1296540104;
  localparam logic signed [31:0] ATANH [20] = '{
    32'sd589812981, 32'sd274247418, 32'sd134923406, 32'sd67196451, 32'sd33565361,
    32'sd16778582, 32'sd8388779, 32'sd4194325, 32'sd2097155, 32'sd1048576,
    32'sd524288, 32'sd262144, 32'sd131072, 32'sd65536, 32'sd32768,
    32'sd16384, 32'sd8192, 32'sd4096, 32'sd2048, 32'sd1024};
  state_t r_state;
  logic [5:0] r_cnt;
  logic [34:0] r_sum;
  logic [34:0] w_sum;
  logic [4:0] w_i;
  logic signed [31:0] w_atanh;
  logic [31:0] w_e [10];
  logic [31:0] w_exp [10];
  logic [31:0] w_s [10];
  // FP32 to signed Q2.30, magnitude clamped to 1.0, tiny values flushed to zero
  function automatic logic signed [31:0] to_q(input logic [31:0] f);
    logic [31:0] m;
    m = f[30:23] >= 8'd127 ? 32'h4000_0000 : f[30:23] < 8'd97 ? 32'd0 :
        {2'b01, f[22:0], 7'd0} >> (8'd127 - f[30:23]);
    return f[31] ? -m : m;
  endfunction
  // Pure-fraction quotient (bit 31 weighs 2^-1) to FP32, mantissa truncated
  function automatic logic [31:0] to_fp(input logic [31:0] q);
    logic [4:0] j;
    j = 5'd0;
    for (int b = 0; b < 32; b++) if (q[b]) j = 5'(31 - b);
    return q == 32'd0 ? 32'd0 : {1'b0, 8'd126 - 8'(j), 23'((q << j) >> 8)};
  endfunction
  assign w_e = '{e1, e2, e3, e4, e5, e6, e7, e8, e9, e10};
  assign {s1, s2, s3, s4, s5} = {w_s[0], w_s[1], w_s[2], w_s[3], w_s[4]};
  assign {s6, s7, s8, s9, s10} = {w_s[5], w_s[6], w_s[7], w_s[8], w_s[9]};
  // iteration index 1..20 with 4 and 13 repeated, and its atanh constant
  assign w_i = 5'(r_cnt < 6'd4 ? r_cnt + 6'd1 : r_cnt < 6'd14 ? r_cnt : r_cnt - 6'd1);
  assign w_atanh = ATANH[w_i - 5'd1];
  // shared denominator over all ten exponentials
  always_comb begin
    w_sum = '0;
    for (int j = 0; j < 10; j++) w_sum = w_sum + 35'(w_exp[j]);
  end
  // sequencer: 22 CORDIC steps, exp/sum capture plus 32 divide steps, one pack cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_sum <= '0;
    end else begin
      r_cnt <= r_state == IDLE || (r_state == CORDIC && r_cnt == 6'd21) ? 6'd0 : r_cnt + 6'd1;
      r_sum <= r_state == DIVIDE && r_cnt == 6'd0 ? w_sum : r_sum;
      r_state <= r_state == IDLE ? (EN ? CORDIC : IDLE) :
                 r_state == CORDIC ? (r_cnt == 6'd21 ? DIVIDE : CORDIC) :
                 r_state == DIVIDE ? (r_cnt == 6'd32 ? PACK : DIVIDE) : IDLE;
    end
  for (genvar g = 0; g < 10; g++) begin : g_lane
    logic signed [31:0] r_x, r_y, r_z;
    logic [34:0] r_rem;
    logic [31:0] r_q, r_s;
    logic [35:0] w_r2;
    logic w_ge;
    assign w_exp[g] = r_x + r_y;
    assign w_s[g] = r_s;
    assign w_r2 = {r_rem, 1'b0};
    assign w_ge = w_r2 >= {1'b0, r_sum};
    // lane datapath: capture, rotate toward z=0, divide by the sum, pack on completion
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_x <= '0;
        r_y <= '0;
        r_z <= '0;
        r_rem <= '0;
        r_q <= '0;
        r_s <= '0;
      end else if (r_state == IDLE && EN) begin
        r_x <= X0;
        r_y <= '0;
        r_z <= to_q(w_e[g]);
      end else if (r_state == CORDIC) begin
        r_x <= r_z[31] ? r_x - (r_y >>> w_i) : r_x + (r_y >>> w_i);
        r_y <= r_z[31] ? r_y - (r_x >>> w_i) : r_y + (r_x >>> w_i);
        r_z <= r_z[31] ? r_z + w_atanh : r_z - w_atanh;
      end else if (r_state == DIVIDE) begin
        r_rem <= r_cnt == 6'd0 ? 35'(w_exp[g]) : 35'(w_ge ? w_r2 - {1'b0, r_sum} : w_r2);
        r_q <= r_cnt == 6'd0 ? 32'd0 : {r_q[30:0], w_ge};
      end else if (r_state == PACK) begin
        r_s <= to_fp(r_q);
      end
  end
endmodule

// File: tb/tb_softmax_parallel.sv
// tb_softmax_parallel: randomized softmax runs checked against a real-valued exp/sum model
module tb_softmax_parallel;
  localparam real TOL = 2.0 ** -16;
  logic clk = 1'b0;
  logic EN, rst_n;
  logic [31:0] e [10];
  logic [31:0] s [10];
  logic [31:0] v [10];
  logic [31:0] ramp [10] = '{32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A, 32'h3ECCCCCD, 32'h3F000000,
                             32'h3F19999A, 32'h3F333333, 32'h3F4CCCCD, 32'h3F666666, 32'h3F800000};
  real want [10];
  real prev [10];
  int n_chk = 0;
  int n_err = 0;

  softmax_parallel dut (
    .e1(e[0]), .e2(e[1]), .e3(e[2]), .e4(e[3]), .e5(e[4]),
    .e6(e[5]), .e7(e[6]), .e8(e[7]), .e9(e[8]), .e10(e[9]),
    .clk(clk), .EN(EN),
    .s1(s[0]), .s2(s[1]), .s3(s[2]), .s4(s[3]), .s5(s[4]),
    .s6(s[5]), .s7(s[6]), .s8(s[7]), .s9(s[8]), .s10(s[9]),
    .rst_n(rst_n));

  always #5 clk = ~clk;

  function automatic real fp2r(input logic [31:0] f);
    real m;
    if (f[30:23] == 8'd0) return 0.0;
    m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (real'(int'(f[30:23])) - 127.0));
    return f[31] ? -m : m;
  endfunction

  function automatic real clampv(input logic [31:0] f);
    real x;
    x = fp2r(f);
    if (f[30:23] == 8'hFF || x > 1.0 || x < -1.0) return f[31] ? -1.0 : 1.0;
    if (x < 2.0 ** -30 && x > -(2.0 ** -30)) return 0.0;
    return x;
  endfunction

  task automatic check(input string tag, input real obs, input real exp, input real tol);
    real d, a;
    n_chk++;
    d = obs > exp ? obs - exp : exp - obs;
    a = exp < 0.0 ? -exp : exp;
    if (d > tol * a) begin
      n_err++;
      $display("FAIL %s: got %.9g expected %.9g", tag, obs, exp);
    end
  endtask

  task automatic model();
    real t [10];
    real sum;
    sum = 0.0;
    foreach (v[j]) begin
      t[j] = $exp(clampv(v[j]));
      sum += t[j];
    end
    foreach (v[j]) want[j] = t[j] / sum;
  endtask

  task automatic rand_v();
    foreach (v[j]) v[j] = {1'($urandom), 31'($urandom_range(32'h3F800001, j == 9 ? 32'h322BCC77 : 32'h38D1B7E5))};
  endtask

  // start on the next edge, hold EN for len edges (optionally toggling it mid-run),
  // scramble inputs after capture, check hold at k+55 and the result at k+56
  task automatic run(input int len, input bit tog);
    real tot;
    @(negedge clk);
    rst_n = 1'b1;
    EN = 1'b1;
    e = v;
    @(posedge clk);
    for (int n = 1; n <= 56; n++) begin
      @(negedge clk);
      EN = (n < len) || (tog && n % 3 == 0);
      foreach (e[j]) e[j] = $urandom;
      @(posedge clk);
      #1;
      if (n == 55) foreach (s[j]) check($sformatf("hold_s%0d", j + 1), fp2r(s[j]), prev[j], TOL);
    end
    EN = 1'b0;
    model();
    tot = 0.0;
    foreach (s[j]) begin
      check($sformatf("s%0d", j + 1), fp2r(s[j]), want[j], TOL);
      tot += fp2r(s[j]);
      prev[j] = want[j];
    end
    check("sum", tot, 1.0, 2.0 ** -14);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    EN = 1'b0;
    foreach (e[j]) e[j] = '0;
    foreach (prev[j]) prev[j] = 0.0;
    repeat (2) @(posedge clk);
    #1;
    foreach (s[j]) check($sformatf("rst_s%0d", j + 1), fp2r(s[j]), 0.0, 0.0);
    foreach (v[j]) v[j] = 32'h3F000000;
    run(1, 1'b0);
    check("equal_s1", fp2r(s[0]), 0.1, TOL);
    v = ramp;
    run(1, 1'b0);
    check("ramp_s1", fp2r(s[0]), 0.061207, TOL);
    check("ramp_s10", fp2r(s[9]), 0.150545, TOL);
    foreach (v[j]) v[j] = '0;
    run(1, 1'b0);
    rand_v();
    v[9] = 32'h40000000;
    run(1, 1'b0);
    v[9] = 32'h3F800000;
    run(1, 1'b0);
    v[0] = 32'h7FC00000;
    v[1] = 32'hFF800000;
    v[2] = 32'h00000001;
    run(1, 1'b0);
    rand_v();
    run(2, 1'b0);
    rand_v();
    run(1, 1'b1);
    repeat (40) @(negedge clk);
    foreach (s[j]) check($sformatf("idle_s%0d", j + 1), fp2r(s[j]), prev[j], TOL);
    rand_v();
    @(negedge clk);
    EN = 1'b1;
    e = v;
    @(negedge clk);
    EN = 1'b0;
    repeat (28) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    foreach (s[j]) check($sformatf("midrst_s%0d", j + 1), fp2r(s[j]), 0.0, 0.0);
    foreach (prev[j]) prev[j] = 0.0;
    rand_v();
    run(1, 1'b0);
    repeat (60) begin
      rand_v();
      run(1, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
